// File: rtl/atm_pin_entry_pkg.sv
// Shared definitions for the ATM keypad front end: key codes, FSM states and defaults.
package atm_pin_entry_pkg;

    localparam int PIN_DIGITS_DEF = 4;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_BACK   = 4'hB;
    localparam logic [3:0] KEY_ENTER  = 4'hC;
    localparam logic [3:0] KEY_CANCEL = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PRESENT,
        ST_WAIT_RES,
        ST_AUTH,
        ST_EJECT,
        ST_LOCKED
    } state_e;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/atm_pin_entry_if.sv
// Keypad input, PIN valid/ready handshake and verification-result strobe.
interface atm_pin_entry_if
    import atm_pin_entry_pkg::*;
#(
    parameter int PIN_DIGITS = PIN_DIGITS_DEF
);
    logic                    key_valid;
    logic [3:0]              key_code;
    logic                    pin_valid;
    logic                    pin_ready;
    logic [4*PIN_DIGITS-1:0] pin_code;
    logic [2:0]              digit_count;
    logic                    result_valid;
    logic                    result_ok;

    // master: the PIN entry block; slave: keypad plus downstream verifier
    modport master (
        input  key_valid, key_code, pin_ready, result_valid, result_ok,
        output pin_valid, pin_code, digit_count
    );

    modport slave (
        output key_valid, key_code, pin_ready, result_valid, result_ok,
        input  pin_valid, pin_code, digit_count
    );

endinterface

// File: rtl/atm_idle_timer.sv
// Inactivity counter: counts enabled cycles since the last clear, flags the final count.
module atm_idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int              W    = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // NOTE: cnt_d gets a default first so no path through this block infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && cnt_q != LAST) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/atm_pin_entry.sv
// Keypad PIN collector: digit shift buffer, PIN handshake, retry counting and lockout FSM.
module atm_pin_entry
    import atm_pin_entry_pkg::*;
#(
    parameter int PIN_DIGITS  = PIN_DIGITS_DEF,
    parameter int TIMEOUT_CYC = 1000,
    parameter int MAX_TRIES   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  card_in_i,
    atm_pin_entry_if.master       pin_if,
    output logic                  auth_ok_o,
    output logic [2:0]            tries_left_o,
    output logic                  locked_o,
    output logic                  cancel_req_o,
    output logic                  timeout_o
);
    localparam int         W         = 4 * PIN_DIGITS;
    localparam logic [2:0] FULL_CNT  = 3'(PIN_DIGITS);
    localparam logic [2:0] TRIES_MAX = 3'(MAX_TRIES);

    state_e         state_q, state_d;
    logic [W-1:0]   buf_q, buf_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [2:0]     tries_q, tries_d;
    logic           pin_valid_q, pin_valid_d;
    logic           auth_q, auth_d;
    logic           locked_q, locked_d;
    logic           cancel_q, cancel_d;
    logic           timeout_q, timeout_d;
    logic           expired;

    atm_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   ((state_q != ST_COLLECT) || pin_if.key_valid),
        .enable_i  (state_q == ST_COLLECT),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        tries_d   = tries_q;
        cancel_d  = 1'b0;
        timeout_d = 1'b0;

        // Card removal in an active session wins over any same-cycle key or result.
        if (!card_in_i && state_q inside {ST_COLLECT, ST_PRESENT, ST_WAIT_RES, ST_AUTH}) begin
            state_d = ST_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (card_in_i) begin
                    state_d = ST_COLLECT;
                    buf_d   = '0;
                    cnt_d   = '0;
                    tries_d = TRIES_MAX;
                end
                ST_COLLECT: begin
                    if (pin_if.key_valid) begin
                        if (is_digit(pin_if.key_code)) begin
                            if (cnt_q < FULL_CNT) begin
                                buf_d = {buf_q[W-5:0], pin_if.key_code};
                                cnt_d = cnt_q + 3'd1;
                            end
                        end else begin
                            case (pin_if.key_code)
                                KEY_CLEAR: begin
                                    buf_d = '0;
                                    cnt_d = '0;
                                end
                                KEY_BACK: if (cnt_q != 3'd0) begin
                                    buf_d = buf_q >> 4;
                                    cnt_d = cnt_q - 3'd1;
                                end
                                KEY_ENTER: if (cnt_q == FULL_CNT) state_d = ST_PRESENT;
                                KEY_CANCEL: begin
                                    cancel_d = 1'b1;
                                    state_d  = ST_EJECT;
                                    buf_d    = '0;
                                    cnt_d    = '0;
                                end
                                default: ;
                            endcase
                        end
                    end else if (expired) begin
                        timeout_d = 1'b1;
                        cancel_d  = 1'b1;
                        state_d   = ST_EJECT;
                        buf_d     = '0;
                        cnt_d     = '0;
                    end
                end
                ST_PRESENT: if (pin_if.pin_ready) state_d = ST_WAIT_RES;
                ST_WAIT_RES: if (pin_if.result_valid) begin
                    if (pin_if.result_ok) begin
                        state_d = ST_AUTH;
                    end else begin
                        tries_d = (tries_q != 3'd0) ? tries_q - 3'd1 : 3'd0;
                        state_d = (tries_d == 3'd0) ? ST_LOCKED : ST_COLLECT;
                        buf_d   = '0;
                        cnt_d   = '0;
                    end
                end
                ST_EJECT: if (!card_in_i) state_d = ST_IDLE;
                default: ;
            endcase
        end

        pin_valid_d = (state_d == ST_PRESENT);
        auth_d      = (state_d == ST_AUTH);
        locked_d    = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            cnt_q       <= '0;
            tries_q     <= TRIES_MAX;
            pin_valid_q <= 1'b0;
            auth_q      <= 1'b0;
            locked_q    <= 1'b0;
            cancel_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            tries_q     <= tries_d;
            pin_valid_q <= pin_valid_d;
            auth_q      <= auth_d;
            locked_q    <= locked_d;
            cancel_q    <= cancel_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pin_if.pin_valid   = pin_valid_q;
    assign pin_if.pin_code    = buf_q;
    assign pin_if.digit_count = cnt_q;
    assign auth_ok_o          = auth_q;
    assign tries_left_o       = tries_q;
    assign locked_o           = locked_q;
    assign cancel_req_o       = cancel_q;
    assign timeout_o          = timeout_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Self-checking bench for atm_pin_entry; transferred PINs are scored against a queue of expected codes.
module tb_atm_pin_entry;
    import atm_pin_entry_pkg::*;

    localparam int PD = 4;
    localparam int TO = 20;
    localparam int MT = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       card_in = 1'b0;
    logic       auth_ok, locked, cancel_req, timeout;
    logic [2:0] tries_left;

    atm_pin_entry_if #(.PIN_DIGITS(PD)) pif ();

    atm_pin_entry #(.PIN_DIGITS(PD), .TIMEOUT_CYC(TO), .MAX_TRIES(MT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .card_in_i    (card_in),
        .pin_if       (pif),
        .auth_ok_o    (auth_ok),
        .tries_left_o (tries_left),
        .locked_o     (locked),
        .cancel_req_o (cancel_req),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every accepted PIN must match the oldest expected code.
    always @(negedge clk) begin
        if (rst_n && pif.pin_valid && pif.pin_ready) begin
            if (exp_q.size() == 0) check("pin_unexpected", 32'(pif.pin_valid), 32'd0);
            else                   check("pin_xfer", 32'(pif.pin_code), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        pif.key_valid = 1'b1;
        pif.key_code  = k;
        tick();
        pif.key_valid = 1'b0;
        pif.key_code  = 4'h0;
    endtask

    task automatic press_digits(input logic [15:0] pin);
        for (int i = 3; i >= 0; i--) press(pin[4*i +: 4]);
    endtask

    task automatic give_result(input logic ok);
        pif.result_valid = 1'b1;
        pif.result_ok    = ok;
        tick();
        pif.result_valid = 1'b0;
        pif.result_ok    = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_code"},   32'(pif.pin_code),    32'h0);
        check({tag, "_count"},  32'(pif.digit_count), 32'd0);
        check({tag, "_tries"},  32'(tries_left),      32'(MT));
        check({tag, "_pvalid"}, 32'(pif.pin_valid),   32'd0);
        check({tag, "_auth"},   32'(auth_ok),         32'd0);
        check({tag, "_locked"}, 32'(locked),          32'd0);
        check({tag, "_cancel"}, 32'(cancel_req),      32'd0);
        check({tag, "_tmo"},    32'(timeout),         32'd0);
    endtask

    initial begin
        int waited;
        pif.key_valid    = 1'b0;
        pif.key_code     = 4'h0;
        pif.pin_ready    = 1'b0;
        pif.result_valid = 1'b0;
        pif.result_ok    = 1'b0;

        #12;
        check_reset_outs("rst");
        tick();
        rst_n = 1'b1;

        // Happy path: 1305 accepted, authenticated, card removed.
        card_in = 1'b1;
        tick();
        press_digits(16'h1305);
        check("s1_count", 32'(pif.digit_count), 32'd4);
        check("s1_code",  32'(pif.pin_code),    32'h1305);
        pif.pin_ready = 1'b1;
        exp_q.push_back(16'h1305);
        press(KEY_ENTER);
        check("s1_pvalid_hi", 32'(pif.pin_valid), 32'd1);
        tick();
        check("s1_pvalid_lo", 32'(pif.pin_valid), 32'd0);
        give_result(1'b1);
        check("s1_auth", 32'(auth_ok), 32'd1);
        card_in = 1'b0;
        tick();
        check("s1_auth_off", 32'(auth_ok),      32'd0);
        check("s1_code_clr", 32'(pif.pin_code), 32'h0);

        // Editing keys, full-buffer digit ignored, three failed rounds to lockout.
        card_in = 1'b1;
        tick();
        press(4'h1); press(4'h2);
        check("s2_12", 32'(pif.pin_code), 32'h12);
        press(KEY_BACK);
        check("s2_back_code",  32'(pif.pin_code),    32'h1);
        check("s2_back_count", 32'(pif.digit_count), 32'd1);
        press(4'h7);
        check("s2_17", 32'(pif.pin_code), 32'h17);
        press(KEY_CLEAR);
        check("s2_clr_code",  32'(pif.pin_code),    32'h0);
        check("s2_clr_count", 32'(pif.digit_count), 32'd0);
        press_digits(16'h9865);
        press(4'h4);
        press(4'hE);
        check("s2_full_code",  32'(pif.pin_code),    32'h9865);
        check("s2_full_count", 32'(pif.digit_count), 32'd4);
        exp_q.push_back(16'h9865);
        press(KEY_ENTER);
        check("s2_pvalid", 32'(pif.pin_valid), 32'd1);
        tick();
        give_result(1'b0);
        check("s2_tries2", 32'(tries_left),      32'd2);
        check("s2_recount", 32'(pif.digit_count), 32'd0);
        press(4'h1); press(4'h2); press(4'h3);
        press(KEY_ENTER);
        check("s2_short_enter", 32'(pif.pin_valid),   32'd0);
        check("s2_short_count", 32'(pif.digit_count), 32'd3);
        press(4'h4);
        pif.pin_ready = 1'b0;
        exp_q.push_back(16'h1234);
        press(KEY_ENTER);
        for (int i = 0; i < 5; i++) begin
            check("s2_hold_valid", 32'(pif.pin_valid), 32'd1);
            check("s2_hold_code",  32'(pif.pin_code),  32'h1234);
            tick();
        end
        pif.pin_ready = 1'b1;
        tick();
        check("s2_released", 32'(pif.pin_valid), 32'd0);
        give_result(1'b0);
        check("s2_tries1", 32'(tries_left), 32'd1);
        press_digits(16'h5555);
        exp_q.push_back(16'h5555);
        press(KEY_ENTER);
        tick();
        give_result(1'b0);
        check("s2_tries0", 32'(tries_left), 32'd0);
        check("s2_locked", 32'(locked),     32'd1);
        card_in = 1'b0;
        tick();
        check("s2_locked_nocard", 32'(locked), 32'd1);
        card_in = 1'b1;
        tick();
        press(4'h2);
        check("s2_locked_key",   32'(pif.digit_count), 32'd0);
        check("s2_locked_card",  32'(locked),          32'd1);
        check("s2_locked_tries", 32'(tries_left),      32'd0);
        rst_n = 1'b0;
        #1;
        check("s2_unlock", 32'(locked),     32'd0);
        check("s2_retry3", 32'(tries_left), 32'(MT));
        tick();
        rst_n = 1'b1;

        // Inactivity timeout after the last key, then eject and reinsert.
        tick();
        press(4'h7);
        check("s3_count", 32'(pif.digit_count), 32'd1);
        waited = 0;
        for (int i = 1; i <= 3 * TO; i++) begin
            tick();
            waited = i;
            if (timeout) break;
        end
        check("s3_latency", 32'(waited),     32'(TO));
        check("s3_tmo",     32'(timeout),    32'd1);
        check("s3_cancel",  32'(cancel_req), 32'd1);
        check("s3_code",    32'(pif.pin_code), 32'h0);
        tick();
        check("s3_tmo_pulse",    32'(timeout),    32'd0);
        check("s3_cancel_pulse", 32'(cancel_req), 32'd0);
        press(4'h5);
        check("s3_eject_key", 32'(pif.digit_count), 32'd0);
        card_in = 1'b0;
        tick();
        card_in = 1'b1;
        tick();
        press(4'h3);
        check("s3_reentry", 32'(pif.digit_count), 32'd1);

        // User cancel.
        press(KEY_CANCEL);
        check("s3_d_cancel", 32'(cancel_req), 32'd1);
        check("s3_d_tmo",    32'(timeout),    32'd0);
        tick();
        check("s3_d_pulse", 32'(cancel_req), 32'd0);
        card_in = 1'b0;
        tick();

        // Card removal beats a pending key; removal during PRESENT drops pin_valid.
        card_in = 1'b1;
        tick();
        press(4'h1); press(4'h2);
        card_in          = 1'b0;
        pif.key_valid    = 1'b1;
        pif.key_code     = 4'h3;
        tick();
        pif.key_valid    = 1'b0;
        check("s4_count", 32'(pif.digit_count), 32'd0);
        check("s4_code",  32'(pif.pin_code),    32'h0);
        card_in = 1'b1;
        tick();
        pif.pin_ready = 1'b0;
        press_digits(16'h4321);
        press(KEY_ENTER);
        check("s4_present", 32'(pif.pin_valid), 32'd1);
        card_in = 1'b0;
        tick();
        check("s4_pv_drop", 32'(pif.pin_valid), 32'd0);
        check("s4_pc_drop", 32'(pif.pin_code),  32'h0);

        // Asynchronous reset while waiting for a verification result.
        card_in       = 1'b1;
        pif.pin_ready = 1'b1;
        tick();
        press_digits(16'h2468);
        exp_q.push_back(16'h2468);
        press(KEY_ENTER);
        tick();
        give_result(1'b0);
        press_digits(16'h1111);
        exp_q.push_back(16'h1111);
        press(KEY_ENTER);
        tick();
        check("s5_tries_pre", 32'(tries_left), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outs("s5_arst");
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
